sdram_slave_model: RTL and testbench
====================================

SDRAM_SLAVE_MODEL -- requirements
Module: sdram_slave_model

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 3: cycles from read acceptance to readdatavalid; legal range 1..7.
REQ-002 SHALL have parameter MAX_PENDING, default 2: maximum accepted reads not yet returned; legal range 1..7.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1: waitrequest cycles inserted before each command is accepted; legal range 0..7.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port chipselect, input, 1 bit: command qualifier.
REQ-007 SHALL have port read_n, input, 1 bit: active-low read request.
REQ-008 SHALL have port write_n, input, 1 bit: active-low write request.
REQ-009 SHALL have port address, input, 32 bits: word address; only address[3:0] is decoded.
REQ-010 SHALL have port byteenable, input, 2 bits: bit0 enables writedata[7:0], bit1 enables writedata[15:8].
REQ-011 SHALL have port writedata, input, 16 bits: write data.
REQ-012 SHALL have port waitrequest, output, 1 bit: stall; command is not accepted while high.
REQ-013 SHALL have port readdatavalid, output, 1 bit: readdata is valid this cycle.
REQ-014 SHALL have port readdata, output, 16 bits: returned read data.

Function
REQ-015 SHALL hold a 16 x 16-bit word memory indexed by address[3:0]; addresses with address[31:4] nonzero alias onto it.
REQ-016 SHALL treat a cycle as a read command when chipselect=1, read_n=0 and write_n=1, and as a write command when chipselect=1, write_n=0 and read_n=1.
REQ-017 SHALL ignore the cycle when read_n=0 and write_n=0 together: no access, no waitrequest, no state change other than clearing the wait counter.
REQ-018 SHALL keep a wait counter that increments each cycle a command is presented and not accepted, and clears on acceptance or when no command is presented.
REQ-019 SHALL drive waitrequest combinationally high while a command is presented and either wait counter < WAIT_CYCLES or (read command and pending = MAX_PENDING and no return this cycle); otherwise low.
REQ-020 SHALL accept a command on a rising edge where the command is presented and waitrequest=0.
REQ-021 SHALL, after each acceptance, restart the wait counter from 0, so back-to-back commands each incur WAIT_CYCLES stall cycles.
REQ-022 SHALL, on an accepted write, update only the enabled bytes of the addressed word; byteenable=00 leaves the word unchanged but still counts as accepted.
REQ-023 SHALL, on a read accepted at edge T, capture the addressed word as it stood before edge T; a write accepted at the same edge is not visible to that read.
REQ-024 SHALL return each accepted read exactly READ_LATENCY cycles after acceptance, with readdatavalid=1 for one cycle, in acceptance order.
REQ-025 SHALL implement the return path as a READ_LATENCY-deep valid/data shift pipeline.
REQ-026 SHALL track pending reads in a counter: +1 on read acceptance, -1 on readdatavalid; simultaneous acceptance and return leave it unchanged.
REQ-027 SHALL never let pending exceed MAX_PENDING or underflow below 0.
REQ-028 SHALL drive readdata = 0 whenever readdatavalid = 0.
REQ-029 SHALL accept writes while reads are pending, without waiting for MAX_PENDING to drain.

Reset
REQ-030 SHALL, while reset=1 at a rising edge, clear all memory words to 0x0000, flush the read pipeline, and clear pending and the wait counter.
REQ-031 SHALL have readdatavalid=0 and readdata=0x0000 from the first edge with reset=1, including reads in flight; flushed reads are never returned.
REQ-032 SHALL hold waitrequest high while reset=1 and a command is presented; no command is accepted during reset.

Verification
REQ-033 SHALL pass this test: after reset, read address 5 with WAIT_CYCLES=1 -> waitrequest high 1 cycle, accepted at edge T, readdatavalid=1 and readdata=0x0000 at T+3.
REQ-034 SHALL pass this test: write 0xABCD to address 3 with byteenable=11, then write 0x1200 with byteenable=10, then read address 3 -> readdata=0x12CD.
REQ-035 SHALL pass this test: write 0x0042 to address 0x00000012, then read address 2 -> readdata=0x0042 (aliasing).
REQ-036 SHALL pass this test: three reads held back-to-back with read_n=0 continuously -> third read stalls until the first returns; returns arrive in order, pending peaks at 2.
REQ-037 SHALL pass this test: a read and then a write of 0x5555 to the same address accepted on consecutive edges -> the read returns the old value and a later read returns 0x5555.
REQ-038 SHALL pass this test: reset asserted 1 cycle after read acceptance -> no readdatavalid pulse ever appears for that read, and a subsequent read of any address returns 0x0000.

Source files
------------

// File: rtl/sdram_slave_model.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sdram_slave_model                                          |
// | Description : Avalon-style SDRAM slave model with a 16-word memory,     |
// |               programmable wait states and fixed-latency pipelined reads.|
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module sdram_slave_model #(
   parameter int READ_LATENCY = 3,
   parameter int MAX_PENDING  = 2,
   parameter int WAIT_CYCLES  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [31:0] address,
   input  logic [1:0]  byteenable,
   input  logic [15:0] writedata,
   output logic        waitrequest,
   output logic        readdatavalid,
   output logic [15:0] readdata
);

   localparam logic [2:0] c_WAIT_MAX = 3'(WAIT_CYCLES);
   localparam logic [2:0] c_PEND_MAX = 3'(MAX_PENDING);

   logic [15:0] r_mem     [16];
   logic [15:0] r_dat_pipe[READ_LATENCY];
   logic        r_vld_pipe[READ_LATENCY];
   logic [2:0]  r_wait_cnt;
   logic [2:0]  r_pending;

   logic        w_rd_cmd;
   logic        w_wr_cmd;
   logic        w_cmd;
   logic        w_ret;
   logic        w_stall;
   logic        w_acc;
   logic        w_acc_rd;
   logic        w_acc_wr;
   logic [3:0]  w_addr;
   logic        w_unused_addr;

   assign w_addr        = address[3:0];
   assign w_unused_addr = ^address[31:4];

   assign w_rd_cmd = chipselect && !read_n && write_n;
   assign w_wr_cmd = chipselect && !write_n && read_n;
   assign w_cmd    = w_rd_cmd || w_wr_cmd;
   assign w_ret    = r_vld_pipe[READ_LATENCY-1];

   // A return in the same cycle frees a slot, so a full tracker need not stall.
   assign w_stall     = (r_wait_cnt < c_WAIT_MAX) ||
                        (w_rd_cmd && (r_pending == c_PEND_MAX) && !w_ret);
   assign waitrequest = w_cmd && (reset || w_stall);

   assign w_acc    = w_cmd && !waitrequest;
   assign w_acc_rd = w_acc && w_rd_cmd;
   assign w_acc_wr = w_acc && w_wr_cmd;

   assign readdatavalid = w_ret;
   assign readdata      = w_ret ? r_dat_pipe[READ_LATENCY-1] : 16'h0000;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            r_mem[i] <= 16'h0000;
         end
      end else if (w_acc_wr) begin
         if (byteenable[0]) begin
            r_mem[w_addr][7:0] <= writedata[7:0];
         end
         if (byteenable[1]) begin
            r_mem[w_addr][15:8] <= writedata[15:8];
         end
      end
   end

   // Stage 0 samples the memory before this edge's write lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_vld_pipe[i] <= 1'b0;
            r_dat_pipe[i] <= 16'h0000;
         end
      end else begin
         r_vld_pipe[0] <= w_acc_rd;
         r_dat_pipe[0] <= r_mem[w_addr];
         for (int i = READ_LATENCY - 1; i > 0; i--) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_dat_pipe[i] <= r_dat_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= 3'd0;
      end else begin
         case ({w_acc_rd, w_ret})
            2'b10:   r_pending <= r_pending + 3'd1;
            2'b01:   r_pending <= (r_pending != 3'd0) ? r_pending - 3'd1 : 3'd0;
            default: r_pending <= r_pending;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait_cnt <= 3'd0;
      end else if (!w_cmd || w_acc) begin
         r_wait_cnt <= 3'd0;
      end else if (r_wait_cnt < c_WAIT_MAX) begin
         r_wait_cnt <= r_wait_cnt + 3'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdram_slave_model.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sdram_slave_model                                       |
// | Description : Scoreboard bench for sdram_slave_model.                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_sdram_slave_model;

   localparam int c_RL = 3;
   localparam int c_MP = 2;
   localparam int c_WC = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        chipselect = 1'b0;
   logic        read_n = 1'b1;
   logic        write_n = 1'b1;
   logic [31:0] address = 32'h0;
   logic [1:0]  byteenable = 2'b00;
   logic [15:0] writedata = 16'h0;
   logic        waitrequest;
   logic        readdatavalid;
   logic [15:0] readdata;

   always #5 clk = ~clk;

   sdram_slave_model #(
      .READ_LATENCY(c_RL),
      .MAX_PENDING (c_MP),
      .WAIT_CYCLES (c_WC)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .chipselect   (chipselect),
      .read_n       (read_n),
      .write_n      (write_n),
      .address      (address),
      .byteenable   (byteenable),
      .writedata    (writedata),
      .waitrequest  (waitrequest),
      .readdatavalid(readdatavalid),
      .readdata     (readdata)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Reference model: memory image, wait/pending counters, expected returns
   typedef struct {
      logic [15:0] data;
      int          due;
   } rd_t;
   rd_t         sb[$];
   logic [15:0] m_mem[16];
   int          m_wait = 0;
   int          m_pend = 0;

   initial begin
      for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
   end

   always @(negedge clk) begin
      bit       is_rd, is_wr, is_cmd, exp_ret, exp_wait, acc;
      logic [3:0] a;
      if (mon_en) begin
         is_rd   = chipselect && !read_n && write_n;
         is_wr   = chipselect && !write_n && read_n;
         is_cmd  = is_rd || is_wr;
         a       = address[3:0];
         exp_ret = (sb.size() > 0) && (sb[0].due == cyc + 1);
         exp_wait = is_cmd && (reset || (m_wait < c_WC) ||
                               (is_rd && (m_pend == c_MP) && !exp_ret));
         check_eq("rdvalid", {31'b0, readdatavalid}, {31'b0, exp_ret});
         check_eq("rddata", {16'b0, readdata}, exp_ret ? {16'b0, sb[0].data} : 32'h0);
         check_eq("waitreq", {31'b0, waitrequest}, {31'b0, exp_wait});
         if (reset) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
            sb.delete();
            m_pend = 0;
            m_wait = 0;
         end else begin
            acc = is_cmd && !exp_wait;
            if (exp_ret) begin
               void'(sb.pop_front());
               m_pend--;
            end
            if (acc && is_rd) begin
               sb.push_back('{data: m_mem[a], due: cyc + 1 + c_RL});
               m_pend++;
            end
            if (acc && is_wr) begin
               if (byteenable[0]) m_mem[a][7:0]  = writedata[7:0];
               if (byteenable[1]) m_mem[a][15:8] = writedata[15:8];
            end
            if (!is_cmd || acc) m_wait = 0;
            else if (m_wait < c_WC) m_wait++;
         end
      end
   end

   // Presents a command and holds it until accepted; returns at posedge+1.
   task automatic issue(input bit wr, input logic [31:0] a, input logic [1:0] be,
                        input logic [15:0] d, output int acc_cyc);
      chipselect = 1'b1;
      read_n     = wr;
      write_n    = !wr;
      address    = a;
      byteenable = be;
      writedata  = d;
      acc_cyc    = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!waitrequest) begin
            acc_cyc = cyc;
            break;
         end
      end
      if (acc_cyc < 0) check_eq("accept_timeout", {31'b0, waitrequest}, 32'h0);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      chipselect = 1'b0;
      read_n     = 1'b1;
      write_n    = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int t;
      int lat;
      int op;
      reset = 1'b1;
      @(posedge clk);
      #1 mon_en = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;

      // first read after reset: check latency directly against the DUT
      issue(1'b0, 32'd5, 2'b11, 16'h0, t);
      chipselect = 1'b0;
      read_n     = 1'b1;
      lat        = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (readdatavalid) begin
            lat = cyc - t;
            break;
         end
      end
      check_eq("read_latency", lat, c_RL);
      @(posedge clk);
      #1;

      issue(1'b1, 32'd3, 2'b11, 16'hABCD, t);
      issue(1'b1, 32'd3, 2'b10, 16'h1200, t);
      issue(1'b0, 32'd3, 2'b11, 16'h0, t);
      idle(6);

      issue(1'b1, 32'h0000_0012, 2'b11, 16'h0042, t);
      issue(1'b0, 32'd2, 2'b11, 16'h0, t);
      idle(6);

      // three reads held continuously: third one waits on pending
      issue(1'b0, 32'd1, 2'b11, 16'h0, t);
      issue(1'b0, 32'd2, 2'b11, 16'h0, t);
      issue(1'b0, 32'd3, 2'b11, 16'h0, t);
      idle(6);

      issue(1'b0, 32'd4, 2'b11, 16'h0, t);
      issue(1'b0, 32'd5, 2'b11, 16'h0, t);
      issue(1'b1, 32'd7, 2'b11, 16'h7777, t);
      issue(1'b0, 32'd7, 2'b11, 16'h0, t);
      idle(6);

      issue(1'b0, 32'd9, 2'b11, 16'h0, t);
      issue(1'b1, 32'd9, 2'b11, 16'h5555, t);
      issue(1'b0, 32'd9, 2'b11, 16'h0, t);
      idle(6);

      chipselect = 1'b1;
      read_n     = 1'b0;
      write_n    = 1'b0;
      address    = 32'd4;
      repeat (3) @(posedge clk);
      #1;
      idle(1);

      issue(1'b1, 32'd3, 2'b00, 16'hFFFF, t);
      issue(1'b0, 32'd3, 2'b11, 16'h0, t);
      idle(6);

      for (int k = 0; k < 60; k++) begin
         op = $urandom_range(0, 3);
         case (op)
            0: issue(1'b0, $urandom, 2'b11, 16'h0, t);
            1: issue(1'b1, $urandom, 2'($urandom_range(0, 3)), 16'($urandom), t);
            2: idle($urandom_range(1, 2));
            default: begin
               chipselect = 1'b1;
               read_n     = 1'b0;
               write_n    = 1'b0;
               address    = $urandom;
               @(posedge clk);
               #1;
            end
         endcase
      end
      idle(8);

      // reset one cycle after a read is accepted, with a read held during reset
      issue(1'b0, 32'd6, 2'b11, 16'h0, t);
      reset      = 1'b1;
      chipselect = 1'b1;
      read_n     = 1'b0;
      write_n    = 1'b1;
      address    = 32'd3;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      idle(8);
      issue(1'b0, 32'd3, 2'b11, 16'h0, t);
      issue(1'b0, 32'd9, 2'b11, 16'h0, t);
      idle(8);

      check_eq("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
